// File: rtl/sequencer_trigger_burst.sv
`default_nettype none
// ============================================================================
//  Module   : sequencer_trigger_burst
//  Purpose  : Upstream stage of the pixel test-structure sequencer. On a
//             start command it issues a burst of run_sequencer triggers. Each
//             trigger is handshaked against the sequencer ready flag, and a
//             programmable gap separates consecutive triggers.
//  Options  : SEQ_TRIG_EXT_GATE_EN - adds the ext_gate input (LEMO IN1),
//             synchronised by two flops. When set, a trigger also needs the
//             gate to be high. When not defined, the gate is treated as
//             always open.
//  Revision : 1.0 - initial release
// ============================================================================
module sequencer_trigger_burst #(
    parameter int CNT_W       = 16,
    parameter int GAP_W       = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_count,
    input  logic [GAP_W-1:0] gap,
    input  logic             seq_ready,
`ifdef SEQ_TRIG_EXT_GATE_EN
    input  logic             ext_gate,
`endif
    output logic             run_sequencer,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent,
    output logic             timeout_err
);

    // Acknowledge watchdog: counts FIRE cycles in which seq_ready is still high
    localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SENT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_FIRE       = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;        // latched burst length
    logic [GAP_W-1:0] gap_q, gap_d;            // latched inter-trigger gap
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;    // remaining GAP cycles
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;    // FIRE cycles without acknowledge
    logic             abort_pend_q, abort_pend_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             terr_q, terr_d;

    logic [CNT_W-1:0] sent_inc;
    logic             gate_ok;

`ifdef SEQ_TRIG_EXT_GATE_EN
    logic [1:0] gate_sync_q;

    // Two-flop synchroniser that brings the LEMO gate into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_sync_q <= 2'b00;
        end else begin
            gate_sync_q <= {gate_sync_q[0], ext_gate};
        end
    end

    assign gate_ok = gate_sync_q[1];
`else
    assign gate_ok = 1'b1;
`endif

    // Saturating increment. The counter never wraps back to zero.
    assign sent_inc = (sent_q == SENT_MAX) ? sent_q : sent_q + 1'b1;

    // Next-state logic, and next values for every registered output
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        abort_pend_d = abort_pend_q;
        sent_d       = sent_q;
        terr_d       = terr_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An abort in IDLE, or one that arrives together with start, is dropped
                abort_pend_d = 1'b0;
                if (start) begin
                    sent_d = '0;
                    terr_d = 1'b0;
                    if (burst_count != '0) begin
                        count_d = burst_count;
                        gap_d   = gap;
                        state_d = S_WAIT_READY;
                    end else begin
                        // An empty burst completes at once and issues no trigger
                        done_d = 1'b1;
                    end
                end
            end

            S_WAIT_READY: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (seq_ready && gate_ok) begin
                    ack_cnt_d = '0;
                    state_d   = S_FIRE;
                end
            end

            S_FIRE: begin
                // A sequencer run is never cut short, so the abort is kept for later
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (!seq_ready) begin
                    sent_d  = sent_inc;
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (seq_ready) begin
                    if ((sent_q == count_q) || abort_pend_q || abort) begin
                        state_d = S_DONE;
                    end else if (gap_q == '0) begin
                        ack_cnt_d = '0;
                        state_d   = S_FIRE;
                    end else begin
                        gap_cnt_d = gap_q - 1'b1;
                        state_d   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_WAIT_READY;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The outputs are decoded from the next state so that they are registered
        // and line up with the state register
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
        run_d  = (state_d == S_FIRE);
        busy_d = (state_d != S_IDLE);
    end

    // State register, burst context and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            ack_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sent_q       <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            abort_pend_q <= abort_pend_d;
            run_q        <= run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sent_q       <= sent_d;
            terr_q       <= terr_d;
        end
    end

    assign run_sequencer = run_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sent          = sent_q;
    assign timeout_err   = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_sequencer_trigger_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequencer_trigger_burst
//  Purpose  : Self-checking bench for sequencer_trigger_burst. A behavioural
//             sequencer drives seq_ready. Trigger, done and sent timing is
//             predicted from the burst rules using cycle arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sequencer_trigger_burst;

    localparam int CNT_W       = 16;
    localparam int GAP_W       = 16;
    localparam int ACK_TIMEOUT = 1023;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] burst_count;
    logic [GAP_W-1:0] gap;
    logic             seq_ready;
`ifdef SEQ_TRIG_EXT_GATE_EN
    logic             ext_gate;
`endif
    logic             run_sequencer;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
    logic             timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Sequencer model state
    bit seq_stuck = 1'b0;
    bit seq_busy  = 1'b0;
    bit ret_now   = 1'b0;
    int drop_at   = 0;
    int back_at   = 0;
    int low_until = 0;
    int last_a    = 1;
    int fixed_a   = 0;
    int fixed_l   = 0;

    sequencer_trigger_burst #(
        .CNT_W       (CNT_W),
        .GAP_W       (GAP_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .burst_count   (burst_count),
        .gap           (gap),
        .seq_ready     (seq_ready),
`ifdef SEQ_TRIG_EXT_GATE_EN
        .ext_gate      (ext_gate),
`endif
        .run_sequencer (run_sequencer),
        .busy          (busy),
        .done          (done),
        .sent          (sent),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Sequencer: after it sees a trigger, it drops ready a cycles later and keeps it low for L cycles
    task automatic seq_model();
        int l;
        ret_now = 1'b0;
        if (seq_stuck) begin
            seq_ready = 1'b1;
            return;
        end
        if (seq_busy && cyc == back_at) begin
            seq_busy = 1'b0;
            ret_now  = 1'b1;
        end else if (!seq_busy && run_sequencer && cyc >= low_until) begin
            seq_busy = 1'b1;
            last_a   = (fixed_a != 0) ? fixed_a : int'($urandom_range(1, 3));
            l        = (fixed_l != 0) ? fixed_l : int'($urandom_range(1, 12));
            drop_at  = cyc + last_a;
            back_at  = drop_at + l;
        end
        seq_ready = !(cyc < low_until) && !(seq_busy && cyc >= drop_at);
    endtask

    task automatic seq_reset();
        seq_busy  = 1'b0;
        ret_now   = 1'b0;
        low_until = 0;
        seq_ready = 1'b1;
    endtask

    // Advance to 1 ns after the next rising edge, then drive the sequencer for the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        seq_model();
    endtask

    // Run one burst. abort_mode: 0 = none, 1 = abort in the GAP after trigger n,
    // 2 = abort during the FIRE of trigger n
    task automatic run_burst(input int cnt, input int g, input int pre,
                             input int abort_mode, input int abort_n);
        int s;
        int exp_rise;
        int exp_done;
        int exp_sent;
        int trig;
        int ndone;
        int abort_at;
        int rise_cyc;
        bit prev_run;
        bit finished;
        bit aborted;
        burst_count = CNT_W'(cnt);
        gap         = GAP_W'(g);
        low_until   = cyc + 1 + pre;
        start       = 1'b1;
        s           = cyc;
        tick();
        start       = 1'b0;
        burst_count = CNT_W'($urandom);
        gap         = GAP_W'($urandom);
        check_eq("busy_rise", busy, 1);
        check_eq("sent_clear", sent, 0);
        check_eq("terr_clear", timeout_err, 0);
        exp_rise = s + 2 + pre;
        exp_done = -1;
        exp_sent = cnt;
        trig     = 0;
        ndone    = 0;
        abort_at = -1;
        rise_cyc = 0;
        prev_run = run_sequencer;
        finished = 1'b0;
        aborted  = 1'b0;
        for (int k = 0; k < 4000 && !finished; k++) begin
            tick();
            abort = 1'b0;
            if (run_sequencer && !prev_run) begin
                check_eq("rise_cycle", cyc, exp_rise);
                check_eq("sent_at_rise", sent, trig);
                trig++;
                rise_cyc = cyc;
                if (abort_mode == 2 && trig == abort_n) begin
                    abort    = 1'b1;
                    aborted  = 1'b1;
                    exp_sent = trig;
                end
            end
            if (!run_sequencer && prev_run) begin
                check_eq("pulse_width", cyc - rise_cyc, last_a + 1);
            end
            if (ret_now) begin
                if (trig >= cnt || aborted) begin
                    exp_done = cyc + 1;
                    exp_rise = -1;
                end else begin
                    exp_rise = (g == 0) ? cyc + 1 : cyc + g + 2;
                    if (abort_mode == 1 && trig == abort_n) begin
                        abort_at = cyc + 2;
                    end
                end
            end
            if (cyc == abort_at) begin
                abort    = 1'b1;
                aborted  = 1'b1;
                exp_sent = trig;
                exp_done = cyc + 1;
                exp_rise = -1;
            end
            if (done) begin
                ndone++;
                check_eq("done_cycle", cyc, exp_done);
            end
            if (exp_done >= 0 && cyc == exp_done + 1) begin
                check_eq("done_count", ndone, 1);
                check_eq("busy_after", busy, 0);
                check_eq("sent_final", sent, exp_sent);
                check_eq("run_after", run_sequencer, 0);
                finished = 1'b1;
            end
            prev_run = run_sequencer;
        end
        abort = 1'b0;
        if (!finished) begin
            check_eq("burst_budget", 0, 1);
        end
    endtask

    task automatic zero_burst();
        bit any_run;
        burst_count = '0;
        gap         = GAP_W'(3);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_sent", sent, 0);
        any_run = run_sequencer;
        tick();
        check_eq("zero_done_off", done, 0);
        for (int k = 0; k < 4; k++) begin
            any_run = any_run | run_sequencer | busy;
            tick();
        end
        check_eq("zero_no_run", any_run, 0);
    endtask

    task automatic timeout_burst();
        int s;
        int rise;
        seq_stuck   = 1'b1;
        burst_count = CNT_W'(2);
        gap         = GAP_W'(1);
        start       = 1'b1;
        s           = cyc;
        tick();
        start       = 1'b0;
        for (int k = 0; k < 10 && !run_sequencer; k++) tick();
        check_eq("to_rise_cycle", cyc, s + 2);
        rise = cyc;
        for (int k = 0; k < ACK_TIMEOUT + 50 && run_sequencer; k++) tick();
        check_eq("to_width", cyc - rise, ACK_TIMEOUT);
        check_eq("to_err", timeout_err, 1);
        check_eq("to_done", done, 1);
        check_eq("to_sent", sent, 0);
        tick();
        check_eq("to_busy_after", busy, 0);
        check_eq("to_err_sticky", timeout_err, 1);
        seq_stuck = 1'b0;
        seq_reset();
        tick();
    endtask

    task automatic reset_mid_fire();
        int  nr;
        bit  pr;
        burst_count = CNT_W'(3);
        gap         = GAP_W'(2);
        low_until   = cyc + 1;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        nr = 0;
        pr = 1'b0;
        for (int k = 0; k < 300 && nr < 2; k++) begin
            tick();
            if (run_sequencer && !pr) nr++;
            pr = run_sequencer;
        end
        check_eq("rst_pre_run", run_sequencer, 1);
        check_eq("rst_pre_sent", sent, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_run", run_sequencer, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_sent", sent, 0);
        check_eq("rst_async_terr", timeout_err, 0);
        seq_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_idle_busy", busy, 0);
    endtask

`ifdef SEQ_TRIG_EXT_GATE_EN
    task automatic gate_test();
        int c;
        bit any_run;
        ext_gate    = 1'b0;
        repeat (3) tick();
        burst_count = CNT_W'(1);
        gap         = '0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        any_run     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            any_run = any_run | run_sequencer;
        end
        check_eq("gate_blocked", any_run, 0);
        ext_gate = 1'b1;
        c = cyc;
        for (int k = 0; k < 10 && !run_sequencer; k++) tick();
        check_eq("gate_rise_cycle", cyc, c + 3);
        for (int k = 0; k < 100 && busy; k++) tick();
        check_eq("gate_end_sent", sent, 1);
    endtask
`endif

    initial begin
        int cnt;
        int g;
        int mode;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        burst_count = '0;
        gap         = '0;
        seq_ready   = 1'b1;
`ifdef SEQ_TRIG_EXT_GATE_EN
        ext_gate    = 1'b1;
`endif
        repeat (3) tick();
        check_eq("rst_run", run_sequencer, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sent", sent, 0);
        check_eq("rst_terr", timeout_err, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Nominal burst: the sequencer drops ready 1 cycle after the trigger and keeps it low for 10 cycles
        fixed_a = 1;
        fixed_l = 10;
        run_burst(3, 5, 0, 0, 0);
        fixed_a = 0;
        fixed_l = 0;

        zero_burst();
        timeout_burst();
        run_burst(1, 0, 1, 0, 0);

        run_burst(10, 100, 0, 1, 2);
        run_burst(10, 3, 0, 2, 4);

        reset_mid_fire();
        run_burst(2, 1, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            cnt  = int'($urandom_range(1, 4));
            g    = int'($urandom_range(0, 6));
            mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
            run_burst(cnt, g, int'($urandom_range(0, 3)), mode, int'($urandom_range(1, cnt)));
        end

`ifdef SEQ_TRIG_EXT_GATE_EN
        gate_test();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
